// File: rtl/sigmoid_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sigmoid_arbiter
// Description : Credit-based round-robin arbiter sharing one fixed-latency,
//               in-order sigmoid unit among NREQ requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module sigmoid_arbiter #(
    parameter int NREQ    = 4,
    parameter int SIG_LAT = 2,
    parameter int CREDITS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [16*NREQ-1:0]   req_x,
    output logic [NREQ-1:0]      req_ready,
    output logic [15:0]          sig_x_out,
    output logic                 sig_valid_out,
    input  logic [15:0]          sig_y_in,
    input  logic                 sig_valid_in,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [16*NREQ-1:0]   rsp_y,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic                 err,
    output logic                 busy
);

    localparam int c_IDX_W     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_TAG_DEPTH = (SIG_LAT + 2 > 4) ? (SIG_LAT + 2) : 4;
    localparam int c_TAG_PW    = $clog2(c_TAG_DEPTH);
    localparam int c_TAG_CW    = $clog2(c_TAG_DEPTH + 1);
    localparam int c_CRED_W    = $clog2(CREDITS + 1);
    localparam int c_RSP_PW    = (CREDITS > 1) ? $clog2(CREDITS) : 1;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [c_IDX_W-1:0]  r_rr_ptr;
    logic [NREQ-1:0]     w_eligible;
    logic                w_grant_valid;
    logic [c_IDX_W-1:0]  w_grant_idx;
    logic                w_xfer;
    logic                w_tag_full;
    int                  w_scan;

    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        w_scan        = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_scan = int'(r_rr_ptr) + k;
            if (w_scan >= NREQ) begin
                w_scan = w_scan - NREQ;
            end
            if (!w_grant_valid && w_eligible[w_scan]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = c_IDX_W'(w_scan);
            end
        end
    end

    // Reset masks the accept so nothing is granted on a reset edge.
    assign w_xfer = w_grant_valid && !rst;

    always_comb begin
        req_ready = '0;
        if (w_xfer) begin
            req_ready[w_grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_xfer) begin
            r_rr_ptr <= (w_grant_idx == c_IDX_W'(NREQ - 1)) ? '0
                                                             : w_grant_idx + c_IDX_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Issue stage
    // ------------------------------------------------------------------
    logic        r_issue_valid;
    logic [15:0] r_issue_x;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_issue_valid <= 1'b0;
            r_issue_x     <= '0;
        end else begin
            r_issue_valid <= w_xfer;
            if (w_xfer) begin
                r_issue_x <= req_x[16*int'(w_grant_idx) +: 16];
            end
        end
    end

    assign sig_valid_out = r_issue_valid;
    assign sig_x_out     = r_issue_x;

    // ------------------------------------------------------------------
    // Tag FIFO: tags are pushed at the transfer edge so the tag is already
    // present while the operand sits in the issue stage.
    // ------------------------------------------------------------------
    logic [c_IDX_W-1:0]  r_tag_mem [c_TAG_DEPTH];
    logic [c_TAG_PW-1:0] r_tag_wr;
    logic [c_TAG_PW-1:0] r_tag_rd;
    logic [c_TAG_CW-1:0] r_tag_cnt;
    logic                w_tag_pop;
    logic                w_tag_empty;
    logic [c_IDX_W-1:0]  w_tag_head;

    assign w_tag_empty = (r_tag_cnt == '0);
    assign w_tag_full  = (r_tag_cnt == c_TAG_CW'(c_TAG_DEPTH));
    assign w_tag_pop   = sig_valid_in && !w_tag_empty;
    assign w_tag_head  = r_tag_mem[r_tag_rd];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_wr  <= '0;
            r_tag_rd  <= '0;
            r_tag_cnt <= '0;
            for (int j = 0; j < c_TAG_DEPTH; j++) begin
                r_tag_mem[j] <= '0;
            end
        end else begin
            if (w_xfer) begin
                r_tag_mem[r_tag_wr] <= w_grant_idx;
                r_tag_wr <= (r_tag_wr == c_TAG_PW'(c_TAG_DEPTH - 1)) ? '0
                                                                      : r_tag_wr + c_TAG_PW'(1);
            end
            if (w_tag_pop) begin
                r_tag_rd <= (r_tag_rd == c_TAG_PW'(c_TAG_DEPTH - 1)) ? '0
                                                                      : r_tag_rd + c_TAG_PW'(1);
            end
            if (w_xfer && !w_tag_pop) begin
                r_tag_cnt <= r_tag_cnt + c_TAG_CW'(1);
            end else if (!w_xfer && w_tag_pop) begin
                r_tag_cnt <= r_tag_cnt - c_TAG_CW'(1);
            end
        end
    end

    // A result with no outstanding tag has no owner: drop it and flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (sig_valid_in && w_tag_empty) begin
            err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Per-requester credits and response FIFOs
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            localparam logic [c_IDX_W-1:0] c_IDX = c_IDX_W'(gi);

            logic [c_CRED_W-1:0] r_credit;
            logic [15:0]         r_mem [CREDITS];
            logic [c_RSP_PW-1:0] r_wr;
            logic [c_RSP_PW-1:0] r_rd;
            logic [c_CRED_W-1:0] r_cnt;
            logic                w_dec;
            logic                w_pop;
            logic                w_push;

            assign w_dec  = w_xfer && (w_grant_idx == c_IDX);
            assign w_pop  = (r_cnt != '0) && rsp_ready[gi];
            assign w_push = w_tag_pop && (w_tag_head == c_IDX)
                            && ((r_cnt != c_CRED_W'(CREDITS)) || w_pop);

            assign w_eligible[gi]     = req_valid[gi] && (r_credit != '0) && !w_tag_full;
            assign rsp_valid[gi]      = (r_cnt != '0);
            assign rsp_y[16*gi +: 16] = r_mem[r_rd];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_credit <= c_CRED_W'(CREDITS);
                end else if (w_dec && !w_pop && (r_credit != '0)) begin
                    r_credit <= r_credit - c_CRED_W'(1);
                end else if (!w_dec && w_pop && (r_credit != c_CRED_W'(CREDITS))) begin
                    r_credit <= r_credit + c_CRED_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_wr  <= '0;
                    r_rd  <= '0;
                    r_cnt <= '0;
                    for (int j = 0; j < CREDITS; j++) begin
                        r_mem[j] <= '0;
                    end
                end else begin
                    if (w_push) begin
                        r_mem[r_wr] <= sig_y_in;
                        r_wr <= (r_wr == c_RSP_PW'(CREDITS - 1)) ? '0 : r_wr + c_RSP_PW'(1);
                    end
                    if (w_pop) begin
                        r_rd <= (r_rd == c_RSP_PW'(CREDITS - 1)) ? '0 : r_rd + c_RSP_PW'(1);
                    end
                    if (w_push && !w_pop) begin
                        r_cnt <= r_cnt + c_CRED_W'(1);
                    end else if (!w_push && w_pop) begin
                        r_cnt <= r_cnt - c_CRED_W'(1);
                    end
                end
            end
        end
    endgenerate

    // The tag FIFO already covers the issue stage; it is listed for clarity.
    assign busy = !w_tag_empty || r_issue_valid || (|rsp_valid);

endmodule
`default_nettype wire

// File: tb/tb_sigmoid_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sigmoid_arbiter
// Description : Directed self-checking bench for sigmoid_arbiter with a
//               two-stage hard-sigmoid reference unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sigmoid_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [63:0] req_x = '0;
    logic [3:0]  req_ready;
    logic [15:0] sig_x_out;
    logic        sig_valid_out;
    logic [15:0] sig_y_in;
    logic        sig_valid_in;
    logic [3:0]  rsp_valid;
    logic [63:0] rsp_y;
    logic [3:0]  rsp_ready = 4'hF;
    logic        err;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sigmoid_arbiter #(.NREQ(4), .SIG_LAT(2), .CREDITS(2)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_x         (req_x),
        .req_ready     (req_ready),
        .sig_x_out     (sig_x_out),
        .sig_valid_out (sig_valid_out),
        .sig_y_in      (sig_y_in),
        .sig_valid_in  (sig_valid_in),
        .rsp_valid     (rsp_valid),
        .rsp_y         (rsp_y),
        .rsp_ready     (rsp_ready),
        .err           (err),
        .busy          (busy)
    );

    // Reference sigmoid unit: hard sigmoid 128 + x/8 clamped to 0..256.
    function automatic logic [15:0] sig_model(input logic [15:0] x);
        int t;
        t = 128 + (int'($signed(x)) >>> 3);
        if (t < 0)   t = 0;
        if (t > 256) t = 256;
        return 16'(t);
    endfunction

    logic        m_v1 = 1'b0, m_v2 = 1'b0;
    logic [15:0] m_y1 = '0,   m_y2 = '0;
    logic        inj = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_v1 <= 1'b0; m_v2 <= 1'b0; m_y1 <= '0; m_y2 <= '0;
        end else begin
            m_v1 <= sig_valid_out;
            m_y1 <= sig_model(sig_x_out);
            m_v2 <= m_v1;
            m_y2 <= m_y1;
        end
    end

    assign sig_valid_in = m_v2 | inj;
    assign sig_y_in     = inj ? 16'd77 : m_y2;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int cnt1, cnt_oth, total;
        logic [3:0] seen;

        // ---------------- reset state (requests held high during reset)
        rst = 1'b1;
        req_valid = 4'hF;
        tick();
        tick();
        check_val("rst_req_ready", req_ready, 0);
        check_val("rst_sig_valid", sig_valid_out, 0);
        check_val("rst_sig_x", sig_x_out, 0);
        check_val("rst_rsp_valid", rsp_valid, 0);
        check_val("rst_rsp_y", rsp_y, 0);
        check_val("rst_err", err, 0);
        check_val("rst_busy", busy, 0);
        req_valid = '0;
        rst = 1'b0;

        // ---------------- single request from requester 2, x = 0
        req_x = '0;
        req_valid = 4'b0100;
        #1;
        check_val("single_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        check_val("single_issue_v", sig_valid_out, 1);
        check_val("single_issue_x", sig_x_out, 16'h0000);
        tick();
        check_val("single_t2_rsp", rsp_valid, 0);
        tick();
        check_val("single_t3_rsp", rsp_valid, 0);
        tick();
        check_val("single_t4_rsp", rsp_valid, 4'b0100);
        check_val("single_t4_y", rsp_y[47:32], 16'd128);
        tick();
        check_val("single_t5_rsp", rsp_valid, 0);
        check_val("single_t5_busy", busy, 0);

        // ---------------- fairness: all valid, no backpressure
        reset_dut();
        req_x = {16'd64, 16'd48, 16'd32, 16'd16};
        for (int n = 0; n < 12; n++) begin
            req_valid = (n < 8) ? 4'hF : 4'h0;
            #1;
            if (n < 8)
                check_val($sformatf("fair_grant%0d", n), req_ready, 4'b0001 << (n % 4));
            if (n >= 1 && n <= 8) begin
                check_val($sformatf("fair_issue_v%0d", n), sig_valid_out, 1);
                check_val($sformatf("fair_issue_x%0d", n), sig_x_out, 16 * (((n - 1) % 4) + 1));
            end
            if (n >= 4) begin
                check_val($sformatf("fair_rsp_v%0d", n), rsp_valid, 4'b0001 << ((n - 4) % 4));
                check_val($sformatf("fair_rsp_y%0d", n), rsp_y[16*((n-4)%4) +: 16],
                          128 + 2 * (((n - 4) % 4) + 1));
            end
            tick();
        end
        check_val("fair_drain_busy", busy, 0);

        // ---------------- backpressure on requester 1
        reset_dut();
        rsp_ready = 4'b1101;
        req_valid = 4'hF;
        cnt1 = 0; cnt_oth = 0;
        for (int n = 0; n < 16; n++) begin
            #1;
            if (req_ready[1]) cnt1++;
            if (n >= 8 && (req_ready & 4'b1101) != 0) cnt_oth++;
            tick();
        end
        #1;
        check_val("bp_xfers_r1", cnt1, 2);
        check_val("bp_ready_r1_low", req_ready[1], 0);
        check_val("bp_others_served", cnt_oth > 0, 1);
        check_val("bp_rsp_v1", rsp_valid[1], 1);
        check_val("bp_rsp_y1", rsp_y[31:16], 16'd132);
        rsp_ready = 4'hF;
        tick();
        rsp_ready = 4'b1101;
        cnt1 = 0;
        for (int n = 0; n < 12; n++) begin
            #1;
            if (req_ready[1]) cnt1++;
            tick();
        end
        check_val("bp_after_pulse_r1", cnt1, 1);

        // ---------------- ordering for requester 0
        reset_dut();
        rsp_ready = 4'hF;
        req_valid = 4'b0001;
        req_x = {48'h0, 16'hFA00};
        tick();
        req_x = {48'h0, 16'h0600};
        tick();
        req_valid = '0;
        tick();
        tick();
        check_val("order_first_v", rsp_valid, 4'b0001);
        check_val("order_first_y", rsp_y[15:0], 16'd0);
        tick();
        check_val("order_second_v", rsp_valid, 4'b0001);
        check_val("order_second_y", rsp_y[15:0], 16'd256);

        // ---------------- protocol error
        reset_dut();
        inj = 1'b1;
        tick();
        inj = 1'b0;
        check_val("perr_err", err, 1);
        check_val("perr_rsp", rsp_valid, 0);
        tick(); tick(); tick();
        check_val("perr_sticky", err, 1);
        check_val("perr_rsp_late", rsp_valid, 0);
        reset_dut();
        check_val("perr_cleared", err, 0);

        // ---------------- reset with three operations in flight
        rsp_ready = 4'hF;
        req_valid = 4'b0111;
        tick(); tick(); tick();
        req_valid = '0;
        #1;
        check_val("mid_busy_before", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("mid_busy_after", busy, 0);
        seen = '0;
        for (int n = 0; n < 8; n++) begin
            seen |= rsp_valid;
            tick();
        end
        check_val("mid_no_rsp", seen, 0);
        rsp_ready = '0;
        req_valid = 4'hF;
        total = 0;
        for (int n = 0; n < 16; n++) begin
            #1;
            if (req_ready != 0) total++;
            tick();
        end
        check_val("mid_credits_total", total, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sigmoid_arbiter.md
SIGMOID_ARBITER -- requirements
Module: sigmoid_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one sigmoid unit.
REQ-002 Parameter SIG_LAT, default 2: cycles from sig_valid_out to sig_valid_in; the sigmoid unit is in-order and cannot stall.
REQ-003 Parameter CREDITS, default 2: response-buffer depth per requester.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  NREQ  per-requester request valid.
REQ-007 req_x  in  16*NREQ  signed Q8.8 operand; requester i uses bits [16i+15:16i].
REQ-008 req_ready  out  NREQ  one-hot-or-zero accept.
REQ-009 sig_x_out  out  16  operand to the sigmoid unit's x_in.
REQ-010 sig_valid_out  out  1  drives the sigmoid unit's valid_in.
REQ-011 sig_y_in  in  16  sigmoid unit y_out, Q8.8, range 0..256.
REQ-012 sig_valid_in  in  1  sigmoid unit valid_out.
REQ-013 rsp_valid  out  NREQ  per-requester result valid.
REQ-014 rsp_y  out  16*NREQ  per-requester result, same slicing as req_x.
REQ-015 rsp_ready  in  NREQ  per-requester result accept.
REQ-016 err  out  1  sticky protocol error.
REQ-017 busy  out  1  high while any operation is in flight or any result is buffered.

Function
REQ-018 Eligible(i) = req_valid[i] AND credit[i]>0 AND tag FIFO not full.
REQ-019 Round-robin: grant the first eligible requester scanning from rr_ptr upward, modulo NREQ; req_ready is combinational and asserted only for the granted index.
REQ-020 A transfer occurs on req_valid[i] AND req_ready[i]; then rr_ptr <= (i+1) mod NREQ; with no transfer, rr_ptr holds.
REQ-021 On a transfer, the next cycle has sig_valid_out=1 and sig_x_out=req_x slice i (registered issue stage); otherwise sig_valid_out=0 and sig_x_out holds.
REQ-022 Maximum throughput: one issue per cycle.
REQ-023 On each issue, push tag i into a 4-entry in-order tag FIFO; the FIFO shall be depth ≥ SIG_LAT+2.
REQ-024 On sig_valid_in, pop the tag and write sig_y_in unchanged into requester tag's response FIFO (CREDITS entries).
REQ-025 rsp_valid[i] is asserted the cycle after that write.
REQ-026 End-to-end latency with SIG_LAT=2: handshake at cycle t gives rsp_valid at cycle t+4.
REQ-027 credit[i] resets to CREDITS; it decrements on a transfer from i and increments on rsp_valid[i] AND rsp_ready[i].
REQ-028 Simultaneous credit increment and decrement leave credit[i] unchanged; credit[i] never leaves 0..CREDITS.
REQ-029 Response FIFOs are first-word-fall-through: rsp_y shows the head entry, and a simultaneous push and pop is legal.
REQ-030 Results for the same requester are delivered in issue order.
REQ-031 If sig_valid_in arrives while the tag FIFO is empty, drop the result and set err=1; err clears only on rst.
REQ-032 busy = tag FIFO non-empty OR issue stage valid OR any rsp_valid.

Reset
REQ-033 While rst=1 at a clock edge, the following take these values on that edge: req_ready=0, sig_valid_out=0, sig_x_out=0, rsp_valid=0, rsp_y=0, err=0, busy=0, rr_ptr=0, all FIFOs empty, every credit=CREDITS.
REQ-034 rst mid-operation discards all in-flight tags and buffered results.
REQ-035 The sigmoid unit is reset by the same rst.
REQ-036 The first cycle after rst deasserts accepts requests normally.

Verification
REQ-037 Single request: req_valid[2]=1, req_x=0x0000, rsp_ready all 1 -> one transfer; sig_valid_out one cycle later with sig_x_out=0x0000; model returns 128; rsp_valid[2]=1, rsp_y[2]=128 four cycles after the handshake.
REQ-038 Fairness: all four req_valid held high with no backpressure -> grants 0,1,2,3,0,... on consecutive cycles, one sig_valid_out per cycle, each result routed to its issuer.
REQ-039 Backpressure: rsp_ready[1]=0, requester 1 continuously valid -> exactly 2 transfers from requester 1 and then req_ready[1]=0 while the other requesters keep being served; after one rsp_ready[1] pulse, exactly one more transfer from requester 1 occurs.
REQ-040 Ordering: requester 0 issues x=-1536 then x=1536 -> responses 0 then 256, in that order.
REQ-041 Protocol error: sig_valid_in pulsed with nothing issued -> err=1 and no rsp_valid; err stays 1 until rst.
REQ-042 Reset mid-flight: rst asserted with 3 operations in flight -> after rst, busy=0, no rsp_valid ever appears for those operations, and all credits equal 2.
